// File: rtl/if_fetch.sv
// MIPS32 instruction-fetch stage: owns the PC, keeps one imem read in flight and
// drives the registered IF/ID producer outputs, with stall buffering and branch redirect.
module if_fetch #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target_address,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_valid
);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic [DATA_W-1:0] buf_inst_q, buf_inst_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic              if_valid_q, if_valid_d;

    logic              deliver;
    logic [ADDR_W-1:0] dlv_pc;
    logic [DATA_W-1:0] dlv_inst;

    // Request is gated by reset so nothing reaches memory while the block is held.
    always_comb begin
        imem_req  = rst & (state_q == StIdle) & ~branch_flag;
        imem_addr = pc_q;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        kill_d     = kill_q;
        deliver    = 1'b0;
        dlv_pc     = '0;
        dlv_inst   = '0;

        case (state_q)
            StIdle: begin
                if (branch_flag) begin
                    pc_d = branch_target_address;
                end else if (imem_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_W'(4);
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (branch_flag) begin
                    pc_d   = branch_target_address;
                    kill_d = 1'b1;
                end
                if (imem_rvalid) begin
                    // A response belonging to a redirected fetch is swallowed here.
                    if (kill_q || branch_flag) begin
                        kill_d  = 1'b0;
                        state_d = StIdle;
                    end else if (!stall) begin
                        deliver  = 1'b1;
                        dlv_pc   = req_pc_q;
                        dlv_inst = imem_rdata;
                        state_d  = StIdle;
                    end else begin
                        buf_pc_d   = req_pc_q;
                        buf_inst_d = imem_rdata;
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                if (branch_flag) begin
                    pc_d       = branch_target_address;
                    buf_pc_d   = '0;
                    buf_inst_d = '0;
                    state_d    = StIdle;
                end else if (!stall) begin
                    deliver  = 1'b1;
                    dlv_pc   = buf_pc_q;
                    dlv_inst = buf_inst_q;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output register: branch flushes, stall holds, otherwise deliver or bubble.
    always_comb begin
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        if (branch_flag) begin
            if_valid_d = 1'b0;
            if_inst_d  = '0;
        end else if (!stall) begin
            if (deliver) begin
                if_pc_d    = dlv_pc;
                if_inst_d  = dlv_inst;
                if_valid_d = 1'b1;
            end else begin
                if_inst_d  = '0;
                if_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            buf_pc_q   <= '0;
            buf_inst_q <= '0;
            kill_q     <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            kill_q     <= kill_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;

endmodule
